conv_frame_controller: RTL



---
 rtl/conv_frame_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/conv_frame_controller.sv
// Frame sequencer for the 3x3 convolution datapath: pixel accept, line-buffer strobes, window events.
// Optional CONV_CTRL_ABORT_EN adds an abort input that returns the controller to IDLE.
module conv_frame_controller #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 6,
  parameter int RW    = 6
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CONV_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          start,
  input  logic [1:0]    filter_sel_req,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_wr_en,
  output logic [CW-1:0] lb_wr_col,
  output logic [1:0]    filter_sel,
  output logic          win_valid,
  input  logic          out_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    filt_q, filt_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          abort_w;

`ifdef CONV_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    filt_d      = filt_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    in_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort_w) begin
          filt_d  = filter_sel_req;
          col_d   = '0;
          row_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        in_ready = !win_valid_q || out_ready;
        if (win_valid_q && out_ready) win_valid_d = 1'b0;
        if (in_valid && in_ready) begin
          // A new window overrides the retire of the previous one in the same cycle.
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - RW'(1);
            win_col_d   = col_q - CW'(1);
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (!win_valid_q || out_ready) begin
          win_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_w && state_q != IDLE) begin
      state_d     = IDLE;
      win_valid_d = 1'b0;
      col_d       = '0;
      row_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      filt_q      <= 2'b00;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      filt_q      <= filt_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign lb_wr_en   = in_valid & in_ready;
  assign lb_wr_col  = col_q;
  assign filter_sel = filt_q;
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule
